yd_dbus_arb: RTL and testbench
==============================

Name: yd_dbus_arb

Overview:
- Arbiter that shares the single-port synchronous data RAM between the core data bus and a host/debug requester (loader, DMA, debugger).
- Core has strict priority every cycle. Host accesses use idle core slots.
- A bounded-wait counter forces a one-cycle core stall (c_hold) so the host cannot starve.
- Sits between the core dbus outputs and the data RAM macro.

Parameters:
- AW, 16, data-space address width
- DW, 16, data width
- MAX_WAIT, 8, host wait cycles in WAIT before c_hold is forced (legal range 1..(2**CW)-1)
- CW, 4, wait-counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous and active-low (0 = reset)
- c_req  in  1  core accesses data RAM this cycle (read or write)
- c_addr  in  AW  core address
- c_din  in  DW  core write data
- c_we  in  1  core write enable
- c_dout  out  DW  read data to core
- c_hold  out  1  core must stall this cycle; its access is not performed
- h_req  in  1  host request, held until h_ack
- h_we  in  1  host write (1) / read (0), stable while h_req
- h_addr  in  AW  host address, stable while h_req
- h_wdata  in  DW  host write data
- h_ack  out  1  one-cycle pulse: host access issued to RAM this cycle
- h_rvalid  out  1  one-cycle pulse: h_rdata valid (read only)
- h_rdata  out  DW  host read data
- m_addr  out  AW  RAM address
- m_din  out  DW  RAM write data
- m_we  out  1  RAM write enable
- m_dout  in  DW  RAM read data, 1-cycle latency

Behaviour:
- Reset (rst=0, async): state=IDLE, wait counter=0, c_hold=0. h_ack, h_rvalid, m_we=0. h_rdata=0. m_addr/m_din drive core values.
- States: IDLE, WAIT, HOLD, RESP. State and counter are registered. Bus mux and h_ack are combinational from state and c_req.
- IDLE: h_req=1 -> WAIT with counter cleared. Host is never granted from IDLE (1-cycle minimum request latency).
- WAIT, grant condition is c_req=0:
  - m_* = host signals; h_ack=1.
  - Next state: RESP if h_we=0, else IDLE.
- WAIT, no grant (c_req=1):
  - Core owns the bus; counter++.
  - Counter reaching MAX_WAIT-1 in this cycle -> HOLD next.
- HOLD:
  - c_hold=1; core request ignored (m_we never from core); host granted (h_ack=1).
  - Next state: RESP if read, else IDLE. Counter cleared.
- RESP:
  - h_rvalid=1; h_rdata=m_dout (registered hold of last host read data).
  - Next state: WAIT if h_req=1 (new request), else IDLE.
  - Core may use the bus in RESP.
- c_dout = m_dout unconditionally. Core reads are only issued in cycles it owns, so returned data is always its own.
- c_hold is asserted only in HOLD, exactly one cycle per starvation event. The core repeats the held access on the following cycle.
- h_req dropped before h_ack (protocol violation): WAIT returns to IDLE on the next edge, no access issued.
- Simultaneous core write and host write: core wins unless in HOLD. No write is ever merged or lost.
- Reset mid-access: an in-flight host read never produces h_rvalid. The host must re-request.
- Max host latency from h_req to h_ack: MAX_WAIT+1 cycles.

Test Plan:
- Idle core: c_req=0, host write addr 0x0040 data 0xBEEF -> h_ack one cycle after h_req, m_we=1, m_addr=0x0040. A host read of 0x0040 then gives h_rvalid with h_rdata=0xBEEF one cycle after ack.
- Saturated core: c_req=1 continuously, host read, MAX_WAIT=8 -> h_ack in the HOLD cycle (9 cycles after h_req), c_hold high exactly that cycle, m_we=0 even with c_we=1.
- Gap grant: c_req=1,1,0 after host request -> h_ack on the third WAIT cycle, no c_hold. Core writes 0x1111/0x2222 to 0x10/0x11 land correctly.
- Back-to-back host reads with h_req held through RESP -> RESP->WAIT, second ack no earlier than 1 cycle after the first h_rvalid. Core reads interleaved return their own data on c_dout.
- Async reset: rst=0 asserted mid-WAIT and mid-RESP -> outputs immediately at reset values. No h_rvalid after release. First h_ack no earlier than 2 cycles after rst=1.
- Abandoned request: h_req 1 for one cycle then 0 with c_req=1 -> no h_ack, no h_rvalid, state back to IDLE, counter 0.

Source files
------------

// File: rtl/yd_dbus_arb_if.sv
// Bundle of core data-bus, host requester and data-RAM signals around the dbus arbiter.
// The master modport is the arbiter's view; slave is the surrounding core/host/RAM side.
interface yd_dbus_arb_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
);
  logic          c_req;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_din;
  logic          c_we;
  logic [DW-1:0] c_dout;
  logic          c_hold;
  logic          h_req;
  logic          h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic          h_ack;
  logic          h_rvalid;
  logic [DW-1:0] h_rdata;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  logic          m_we;
  logic [DW-1:0] m_dout;

  modport master (
    input  c_req, c_addr, c_din, c_we, h_req, h_we, h_addr, h_wdata, m_dout,
    output c_dout, c_hold, h_ack, h_rvalid, h_rdata, m_addr, m_din, m_we
  );

  modport slave (
    output c_req, c_addr, c_din, c_we, h_req, h_we, h_addr, h_wdata, m_dout,
    input  c_dout, c_hold, h_ack, h_rvalid, h_rdata, m_addr, m_din, m_we
  );
endinterface

// File: rtl/yd_dbus_arb.sv
// Shares the single-port data RAM between the core (strict priority) and a host requester;
// a bounded wait forces one core stall cycle so the host is never starved.
module yd_dbus_arb #(
  parameter int unsigned AW       = 16,
  parameter int unsigned DW       = 16,
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned CW       = 4
) (
  input  logic            clk,
  input  logic            rst,
  yd_dbus_arb_if.master   bus
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, RESP} state_e;

  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          grant;
  logic          core_we;

  // Host owns the bus on an idle core slot in WAIT, or unconditionally in HOLD.
  assign grant   = ((state_q == WAIT) && bus.h_req && !bus.c_req) || (state_q == HOLD);
  // Core writes are masked while reset is asserted so nothing reaches the RAM.
  assign core_we = rst && bus.c_req && bus.c_we;

  assign bus.h_ack    = grant;
  assign bus.c_hold   = (state_q == HOLD);
  assign bus.h_rvalid = (state_q == RESP);
  assign bus.h_rdata  = (state_q == RESP) ? bus.m_dout : rdata_q;
  assign bus.c_dout   = bus.m_dout;
  assign bus.m_addr   = grant ? bus.h_addr  : bus.c_addr;
  assign bus.m_din    = grant ? bus.h_wdata : bus.c_din;
  assign bus.m_we     = grant ? bus.h_we    : core_we;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.h_req) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (!bus.h_req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!bus.c_req) begin
          state_d = bus.h_we ? IDLE : RESP;
          cnt_d   = '0;
        end else begin
          // Core kept the slot: count the lost cycle, force a stall once the budget is spent.
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == WAIT_LAST) state_d = HOLD;
        end
      end
      HOLD: begin
        state_d = bus.h_we ? IDLE : RESP;
        cnt_d   = '0;
      end
      RESP: begin
        rdata_d = bus.m_dout;
        state_d = bus.h_req ? WAIT : IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_yd_dbus_arb.sv
// Directed bench for yd_dbus_arb: vector table plus hand-written multi-cycle sequences,
// with a small 1-cycle-latency RAM model on the m_* side.
module tb_yd_dbus_arb;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_err = 0;
  int   n_chk = 0;

  always #5 clk = ~clk;

  yd_dbus_arb_if #(.AW(16), .DW(16)) bus ();

  yd_dbus_arb #(.AW(16), .DW(16), .MAX_WAIT(8), .CW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] mem [0:255];

  always @(posedge clk) begin
    if (bus.m_we) mem[bus.m_addr[7:0]] <= bus.m_din;
    bus.m_dout <= mem[bus.m_addr[7:0]];
  end

  typedef struct {
    logic        c_req;
    logic        c_we;
    logic [15:0] c_addr;
    logic [15:0] c_din;
    logic        h_req;
    logic        h_we;
    logic [15:0] h_addr;
    logic [15:0] h_wdata;
    logic [31:0] e_ctrl;
    logic        chk_hr;
    logic [15:0] e_hr;
    logic        chk_cd;
    logic [15:0] e_cd;
  } vec_t;

  function automatic logic [31:0] ctrl_exp(input logic a, input logic r, input logic h,
                                           input logic w, input logic [15:0] addr);
    return {12'd0, a, r, h, w, addr};
  endfunction

  function automatic logic [31:0] ctrl_act();
    return {12'd0, bus.h_ack, bus.h_rvalid, bus.c_hold, bus.m_we, bus.m_addr};
  endfunction

  function automatic vec_t mk(input logic cr, input logic cw, input logic [15:0] ca,
                              input logic [15:0] cd, input logic hr, input logic hw,
                              input logic [15:0] ha, input logic [15:0] hd,
                              input logic [31:0] ec, input logic chr, input logic [15:0] ehr,
                              input logic ccd, input logic [15:0] ecd);
    vec_t v;
    v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_din = cd;
    v.h_req = hr; v.h_we = hw; v.h_addr = ha; v.h_wdata = hd;
    v.e_ctrl = ec; v.chk_hr = chr; v.e_hr = ehr; v.chk_cd = ccd; v.e_cd = ecd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
                       input logic hr, input logic hw, input logic [15:0] ha, input logic [15:0] hd);
    bus.c_req = cr; bus.c_we = cw; bus.c_addr = ca; bus.c_din = cd;
    bus.h_req = hr; bus.h_we = hw; bus.h_addr = ha; bus.h_wdata = hd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Host read against a core that requests every cycle: ack and stall land together 9 cycles in.
  task automatic sat_read(input string nm, input logic [15:0] addr, input logic [15:0] exp_data);
    drive(1'b1, 1'b1, 16'h0020, 16'hAAAA, 1'b1, 1'b0, addr, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 9) chk($sformatf("%s hold cyc%0d", nm, i), ctrl_act(), ctrl_exp(1, 0, 1, 0, addr));
      else        chk($sformatf("%s wait cyc%0d", nm, i), ctrl_act(), ctrl_exp(0, 0, 0, 1, 16'h0020));
      next_cycle();
    end
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    chk({nm, " resp ctrl"}, ctrl_act(), ctrl_exp(0, 1, 0, 0, 16'h0000));
    chk({nm, " resp data"}, 32'(bus.h_rdata), 32'(exp_data));
    next_cycle();
  endtask

  vec_t vt [20];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    bus.m_dout = 16'h0000;

    // Idle core: host write then host read of 0x0040.
    vt[0]  = mk(0,0,16'h0000,16'h0000, 1,1,16'h0040,16'hBEEF, ctrl_exp(0,0,0,0,16'h0000), 0,0, 0,0);
    vt[1]  = mk(0,0,16'h0000,16'h0000, 1,1,16'h0040,16'hBEEF, ctrl_exp(1,0,0,1,16'h0040), 0,0, 0,0);
    vt[2]  = mk(0,0,16'h0000,16'h0000, 0,1,16'h0040,16'hBEEF, ctrl_exp(0,0,0,0,16'h0000), 0,0, 0,0);
    vt[3]  = mk(0,0,16'h0000,16'h0000, 1,0,16'h0040,16'h0000, ctrl_exp(0,0,0,0,16'h0000), 0,0, 0,0);
    vt[4]  = mk(0,0,16'h0000,16'h0000, 1,0,16'h0040,16'h0000, ctrl_exp(1,0,0,0,16'h0040), 0,0, 0,0);
    vt[5]  = mk(0,0,16'h0000,16'h0000, 0,0,16'h0040,16'h0000, ctrl_exp(0,1,0,0,16'h0000), 1,16'hBEEF, 0,0);
    vt[6]  = mk(0,0,16'h0000,16'h0000, 0,0,16'h0040,16'h0000, ctrl_exp(0,0,0,0,16'h0000), 1,16'hBEEF, 0,0);
    // Gap grant: core 1,1,0 after the request; core writes land, host write 0x0050.
    vt[7]  = mk(1,1,16'h0010,16'h1111, 1,1,16'h0050,16'h5555, ctrl_exp(0,0,0,1,16'h0010), 0,0, 0,0);
    vt[8]  = mk(1,1,16'h0011,16'h2222, 1,1,16'h0050,16'h5555, ctrl_exp(0,0,0,1,16'h0011), 0,0, 0,0);
    vt[9]  = mk(1,0,16'h0010,16'h0000, 1,1,16'h0050,16'h5555, ctrl_exp(0,0,0,0,16'h0010), 0,0, 0,0);
    vt[10] = mk(0,0,16'h0000,16'h0000, 1,1,16'h0050,16'h5555, ctrl_exp(1,0,0,1,16'h0050), 0,0, 1,16'h1111);
    vt[11] = mk(1,0,16'h0011,16'h0000, 0,0,16'h0000,16'h0000, ctrl_exp(0,0,0,0,16'h0011), 0,0, 0,0);
    vt[12] = mk(1,0,16'h0050,16'h0000, 0,0,16'h0000,16'h0000, ctrl_exp(0,0,0,0,16'h0050), 0,0, 1,16'h2222);
    vt[13] = mk(0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, ctrl_exp(0,0,0,0,16'h0000), 0,0, 1,16'h5555);
    // Back-to-back host reads, request held through RESP, core reads interleaved.
    vt[14] = mk(1,0,16'h0010,16'h0000, 1,0,16'h0040,16'h0000, ctrl_exp(0,0,0,0,16'h0010), 0,0, 0,0);
    vt[15] = mk(0,0,16'h0000,16'h0000, 1,0,16'h0040,16'h0000, ctrl_exp(1,0,0,0,16'h0040), 0,0, 1,16'h1111);
    vt[16] = mk(1,0,16'h0011,16'h0000, 1,0,16'h0050,16'h0000, ctrl_exp(0,1,0,0,16'h0011), 1,16'hBEEF, 0,0);
    vt[17] = mk(0,0,16'h0000,16'h0000, 1,0,16'h0050,16'h0000, ctrl_exp(1,0,0,0,16'h0050), 0,0, 1,16'h2222);
    vt[18] = mk(0,0,16'h0000,16'h0000, 0,0,16'h0050,16'h0000, ctrl_exp(0,1,0,0,16'h0000), 1,16'h5555, 0,0);
    vt[19] = mk(0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, ctrl_exp(0,0,0,0,16'h0000), 1,16'h5555, 0,0);

    // Reset state, with a core write presented to prove m_we is masked.
    drive(1'b1, 1'b1, 16'h0033, 16'h7777, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    chk("reset ctrl", ctrl_act(), ctrl_exp(0, 0, 0, 0, 16'h0033));
    chk("reset rdata", 32'(bus.h_rdata), 32'h0);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    rst = 1'b1;
    next_cycle();

    for (int i = 0; i < 20; i++) begin
      drive(vt[i].c_req, vt[i].c_we, vt[i].c_addr, vt[i].c_din,
            vt[i].h_req, vt[i].h_we, vt[i].h_addr, vt[i].h_wdata);
      @(negedge clk);
      chk($sformatf("vec%0d ctrl", i), ctrl_act(), vt[i].e_ctrl);
      if (vt[i].chk_hr) chk($sformatf("vec%0d h_rdata", i), 32'(bus.h_rdata), 32'(vt[i].e_hr));
      if (vt[i].chk_cd) chk($sformatf("vec%0d c_dout", i), 32'(bus.c_dout), 32'(vt[i].e_cd));
      next_cycle();
    end

    sat_read("sat1", 16'h0040, 16'hBEEF);

    // Reset mid-WAIT: outputs fall to reset values at once.
    drive(1'b1, 1'b1, 16'h0021, 16'h1234, 1'b1, 1'b0, 16'h0040, 16'h0000);
    next_cycle();
    #2 rst = 1'b0;
    #1;
    chk("rst_wait ctrl", ctrl_act(), ctrl_exp(0, 0, 0, 0, 16'h0021));
    chk("rst_wait rdata", 32'(bus.h_rdata), 32'h0);
    @(posedge clk);
    #1;
    bus.c_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst no ack", ctrl_act(), ctrl_exp(0, 0, 0, 0, 16'h0021));
    next_cycle();
    @(negedge clk);
    chk("post_rst ack", ctrl_act(), ctrl_exp(1, 0, 0, 0, 16'h0040));
    next_cycle();
    // Reset mid-RESP: the in-flight read must never show h_rvalid.
    chk("rst_resp pre rvalid", 32'(bus.h_rvalid), 32'h1);
    #1 rst = 1'b0;
    #1;
    chk("rst_resp ctrl", ctrl_act(), ctrl_exp(0, 0, 0, 0, 16'h0021));
    chk("rst_resp rdata", 32'(bus.h_rdata), 32'h0);
    bus.h_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_resp cyc%0d", i), ctrl_act(), ctrl_exp(0, 0, 0, 0, 16'h0021));
      next_cycle();
    end

    // Abandoned request, with the core busy and then with the core idle.
    for (int cr = 1; cr >= 0; cr--) begin
      drive(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000);
      next_cycle();
      bus.c_req = 1'(cr);
      bus.h_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk($sformatf("abandon cr%0d cyc%0d", cr, i), ctrl_act(),
            ctrl_exp(0, 0, 0, 0, 16'h0010));
        next_cycle();
      end
    end

    // A fresh starved request must again wait the full budget, so the counter restarted.
    sat_read("sat2", 16'h0050, 16'h5555);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1, "timeout");
  end

endmodule
